// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmitter peripheral: register addresses,
// STATUS bit positions, transmit FSM state encoding and the default bit period.
package uart_tx_fifo_pkg;

   localparam logic [2:0] ADDR_DATA = 3'b001;   // W: queue byte, R: 8'h00
   localparam logic [2:0] ADDR_CTRL = 3'b011;   // R: STATUS, W: CTRL

   localparam int STAT_NOT_FULL = 0;
   localparam int STAT_BUSY     = 1;
   localparam int STAT_EMPTY    = 2;
   localparam int STAT_OVF      = 3;

   localparam logic [7:0] PERIOD_DEFAULT = 8'h1A;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_START = 2'b01,
      ST_DATA  = 2'b10,
      ST_STOP  = 2'b11
   } tx_state_e;

   function automatic logic [7:0] pack_status(input logic ovf, input logic empty,
                                              input logic busy, input logic not_full);
      logic [7:0] s;
      s                = 8'h00;
      s[STAT_OVF]      = ovf;
      s[STAT_EMPTY]    = empty;
      s[STAT_BUSY]     = busy;
      s[STAT_NOT_FULL] = not_full;
      return s;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous show-ahead FIFO: rd_data always presents the head entry.
// Ports: clk, reset (async active-low), push/pop/flush strobes, wr_data in,
//        rd_data (head entry), full, empty.
// Push is ignored when full, pop when empty; flush clears everything and
// overrides a same-cycle push or pop.
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   always_comb begin
      full     = (count_q == CW'(DEPTH));
      empty    = (count_q == '0);
      do_push  = push && !full && !flush;
      do_pop   = pop && !empty && !flush;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // Pointers wrap naturally because DEPTH is a power of two.
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         if (do_push && !do_pop)      count_d = count_q + CW'(1);
         else if (do_pop && !do_push) count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/uart_tx_fifo.sv
// Register-mapped UART transmitter with a byte FIFO; sends 8N1 frames on txout.
// Ports: clk, reset (async active-low), wren/rden strobes, addr[2:0], din[7:0]
//        write data, dout[7:0] registered read data, txout serial line (idle high).
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (low) for PERIOD clocks
// DATA  | eight data bits, LSB first, PERIOD clocks each
// STOP  | stop bit (high); chains straight into the next START if a byte waits
module uart_tx_fifo
   import uart_tx_fifo_pkg::*;
#(
   parameter logic [7:0] PERIOD = PERIOD_DEFAULT,
   parameter int         DEPTH  = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wren,
   input  logic       rden,
   input  logic [2:0] addr,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       txout
);
   localparam logic [7:0] BAUD_LAST = PERIOD - 8'd1;

   tx_state_e  state_q, state_d;
   logic [7:0] baud_q, baud_d;
   logic [2:0] bit_idx_q, bit_idx_d;
   logic [7:0] shift_q, shift_d;
   logic       txout_q, txout_d;
   logic [7:0] dout_q, dout_d;
   logic       ovf_q, ovf_d;

   logic       wr_data, wr_flush, rd_status;
   logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic       frame_avail, bit_end;
   logic [7:0] fifo_rd_data;
   logic [7:0] status;

   uart_sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (fifo_push),
      .pop     (fifo_pop),
      .flush   (wr_flush),
      .wr_data (din),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_comb begin
      wr_data   = wren && (addr == ADDR_DATA);
      wr_flush  = wren && (addr == ADDR_CTRL) && din[0];
      rd_status = rden && (addr == ADDR_CTRL);
      // Fullness is judged before any same-cycle pop, so a write to a full
      // FIFO is dropped even if the transmitter drains an entry that cycle.
      fifo_push = wr_data && !fifo_full;
      // A flush beats a same-cycle pop: the FSM must not start a frame on it.
      frame_avail = !fifo_empty && !wr_flush;
      status = pack_status(ovf_q, fifo_empty, state_q != ST_IDLE, !fifo_full);
   end

   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      fifo_pop  = 1'b0;
      bit_end   = (baud_q == BAUD_LAST);
      if (state_q != ST_IDLE) baud_d = bit_end ? 8'd0 : baud_q + 8'd1;
      unique case (state_q)
         ST_IDLE: begin
            baud_d = 8'd0;
            if (frame_avail) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_rd_data;
               state_d  = ST_START;
            end
         end
         ST_START: begin
            if (bit_end) begin
               state_d   = ST_DATA;
               bit_idx_d = 3'd0;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               shift_d   = shift_q >> 1;
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               if (frame_avail) begin
                  fifo_pop = 1'b1;
                  shift_d  = fifo_rd_data;
                  state_d  = ST_START;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Line level follows the state one clock later from a flop, so every bit
   // still lasts exactly PERIOD clocks and txout never glitches.
   always_comb begin
      txout_d = 1'b1;
      unique case (state_q)
         ST_START: txout_d = 1'b0;
         ST_DATA:  txout_d = shift_q[0];
         default:  txout_d = 1'b1;
      endcase
   end

   always_comb begin
      dout_d = dout_q;
      if (rden) dout_d = (addr == ADDR_CTRL) ? status : 8'h00;
      ovf_d = ovf_q;
      if (rd_status)             ovf_d = 1'b0;
      if (wr_data && fifo_full)  ovf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         baud_q    <= 8'd0;
         bit_idx_q <= 3'd0;
         shift_q   <= 8'd0;
         txout_q   <= 1'b1;
         dout_q    <= 8'h00;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         txout_q   <= txout_d;
         dout_q    <= dout_d;
         ovf_q     <= ovf_d;
      end
   end

   assign dout  = dout_q;
   assign txout = txout_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: directed bus traffic pushes expected
// read data and expected frames (byte + start cycle) into queues; separate
// monitors decode txout / dout and compare against the queue heads.
module tb_uart_tx_fifo;
   localparam int P = 4;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       wren  = 1'b0;
   logic       wren2 = 1'b0;
   logic       rden  = 1'b0;
   logic [2:0] addr  = 3'b000;
   logic [7:0] din   = 8'h00;
   logic [7:0] dout, dout2;
   logic       txout, txout2;

   int cyc      = 0;
   int n_checks = 0;
   int n_pass   = 0;
   int rst_cnt  = 0;

   logic [7:0] exp_byte_q [$];
   int         exp_start_q [$];
   logic [7:0] rd_exp_q [$];
   string      rd_name_q [$];
   int         exp2_q [$];

   uart_tx_fifo #(.PERIOD(8'd4), .DEPTH(4)) dut (
      .clk(clk), .reset(rst_n), .wren(wren), .rden(rden), .addr(addr),
      .din(din), .dout(dout), .txout(txout));

   uart_tx_fifo #(.PERIOD(8'd2), .DEPTH(4)) dut2 (
      .clk(clk), .reset(rst_n), .wren(wren2), .rden(rden), .addr(addr),
      .din(din), .dout(dout2), .txout(txout2));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge rst_n) rst_cnt <= rst_cnt + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [7:0] d, input bit sel2,
                            output int edge_cyc);
      addr = a;
      din  = d;
      if (sel2) wren2 = 1'b1;
      else      wren  = 1'b1;
      @(posedge clk);
      #1 edge_cyc = cyc;
      @(negedge clk);
      wren  = 1'b0;
      wren2 = 1'b0;
   endtask

   task automatic bus_read(input logic [2:0] a, input logic [7:0] exp, input string name);
      addr = a;
      rden = 1'b1;
      rd_exp_q.push_back(exp);
      rd_name_q.push_back(name);
      @(posedge clk);
      @(negedge clk);
      rden = 1'b0;
   endtask

   // Read monitor: dout must hold the selected value just after the read edge.
   initial begin : read_mon
      logic [7:0] e;
      string      t;
      forever begin
         @(posedge clk);
         if (rden && rst_n) begin
            if (rd_exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL read_unexpected: read with no expectation queued");
            end else begin
               e = rd_exp_q.pop_front();
               t = rd_name_q.pop_front();
               #1 chk(t, dout, e);
            end
         end
      end
   end

   // Frame monitor for the PERIOD=4 instance: samples mid-bit.
   initial begin : frame_mon
      logic       prev, sb, pb;
      logic [7:0] data;
      int         s, r0;
      prev = 1'b1;
      data = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         if (prev && !txout) begin
            s  = cyc;
            r0 = rst_cnt;
            repeat (P/2) @(posedge clk);
            #1 sb = txout;
            for (int k = 0; k < 8; k++) begin
               repeat (P) @(posedge clk);
               #1 data[k] = txout;
            end
            repeat (P) @(posedge clk);
            #1 pb = txout;
            if (rst_cnt == r0) begin
               if (exp_byte_q.size() == 0) begin
                  n_checks++;
                  $display("FAIL frame_unexpected: got byte %02h starting cycle %0d, expected no frame", data, s);
               end else begin
                  chk("frame_start_cycle", s, exp_start_q.pop_front());
                  chk("frame_data", data, exp_byte_q.pop_front());
                  chk("frame_start_bit", sb, 0);
                  chk("frame_stop_bit", pb, 1);
               end
            end
         end
         prev = txout;
      end
   end

   // Monitor for the PERIOD=2 instance: start-bit timing and low run length.
   initial begin : frame_mon2
      logic prev2;
      int   lowlen;
      prev2 = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (prev2 && !txout2) begin
            if (exp2_q.size() == 0) begin
               n_checks++;
               $display("FAIL p2_unexpected_frame: fall at cycle %0d, expected none", cyc);
            end else begin
               chk("p2_start_cycle", cyc, exp2_q.pop_front());
            end
            lowlen = 0;
            while (!txout2 && lowlen < 100) begin
               lowlen++;
               @(posedge clk);
               #1;
            end
            chk("p2_low_len", lowlen, 18);
         end
         prev2 = txout2;
      end
   end

   initial begin : watchdog
      #3000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin : stim
      int n0, w;
      #12;
      chk("reset_txout", txout, 1);
      chk("reset_dout", dout, 8'h00);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      bus_read(3'b011, 8'h05, "status_after_reset");

      // Reset asserted during a start bit aborts the frame at once.
      bus_write(3'b001, 8'h3C, 1'b0, n0);
      wait_until(n0 + 4);
      chk("midframe_txout_low", txout, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("reset_txout_immediate", txout, 1);
      chk("reset_dout_cleared", dout, 8'h00);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      bus_read(3'b011, 8'h05, "status_after_midframe_reset");
      repeat (45) @(negedge clk);

      // Single byte: start bit falls two clocks after the write edge.
      bus_write(3'b001, 8'hA5, 1'b0, n0);
      exp_byte_q.push_back(8'hA5); exp_start_q.push_back(n0 + 2);
      wait_until(n0 + 48);

      // Back-to-back frames, 40 clocks apart.
      bus_write(3'b001, 8'h01, 1'b0, n0);
      bus_write(3'b001, 8'h02, 1'b0, w);
      bus_write(3'b001, 8'h03, 1'b0, w);
      for (int k = 0; k < 3; k++) begin
         exp_byte_q.push_back(8'(k + 1));
         exp_start_q.push_back(n0 + 2 + 40 * k);
      end
      wait_until(n0 + 10);  bus_read(3'b011, 8'h03, "status_b2b_frame1");
      wait_until(n0 + 50);  bus_read(3'b011, 8'h03, "status_b2b_frame2");
      wait_until(n0 + 90);  bus_read(3'b011, 8'h07, "status_b2b_frame3");
      wait_until(n0 + 125); bus_read(3'b011, 8'h05, "status_b2b_done");

      // Overflow: six writes, first pops immediately, four queue, sixth drops.
      bus_write(3'b001, 8'h11, 1'b0, n0);
      bus_write(3'b001, 8'h22, 1'b0, w);
      bus_write(3'b001, 8'h33, 1'b0, w);
      bus_write(3'b001, 8'h44, 1'b0, w);
      bus_write(3'b001, 8'h55, 1'b0, w);
      bus_write(3'b001, 8'h66, 1'b0, w);
      for (int k = 0; k < 5; k++) begin
         exp_byte_q.push_back(8'(8'h11 * (k + 1)));
         exp_start_q.push_back(n0 + 2 + 40 * k);
      end
      bus_read(3'b011, 8'h0A, "status_overflow");
      bus_read(3'b011, 8'h02, "status_overflow_cleared");
      wait_until(n0 + 215); bus_read(3'b011, 8'h05, "status_overflow_done");

      // Flush during the first frame: it completes, nothing follows.
      bus_write(3'b001, 8'h5A, 1'b0, n0);
      bus_write(3'b001, 8'hC3, 1'b0, w);
      bus_write(3'b001, 8'h7E, 1'b0, w);
      exp_byte_q.push_back(8'h5A); exp_start_q.push_back(n0 + 2);
      wait_until(n0 + 20);
      bus_write(3'b011, 8'h01, 1'b0, w);
      bus_read(3'b011, 8'h07, "status_after_flush");
      wait_until(n0 + 50);  bus_read(3'b011, 8'h05, "status_flush_done");
      wait_until(n0 + 100);

      // Bus corners.
      bus_read(3'b011, 8'h05, "status_idle");
      repeat (3) @(negedge clk);
      chk("dout_hold", dout, 8'h05);
      bus_read(3'b000, 8'h00, "read_addr0");
      bus_read(3'b011, 8'h05, "status_idle2");
      bus_read(3'b101, 8'h00, "read_addr5");
      bus_read(3'b011, 8'h05, "status_idle3");
      bus_read(3'b001, 8'h00, "read_data_reg");
      bus_write(3'b111, 8'h96, 1'b0, w);
      repeat (20) @(negedge clk);
      bus_read(3'b011, 8'h05, "status_after_addr7_write");

      // PERIOD=2 instance: two zero bytes back-to-back, 20-clock frames.
      bus_write(3'b001, 8'h00, 1'b1, n0);
      exp2_q.push_back(n0 + 2);
      exp2_q.push_back(n0 + 22);
      bus_write(3'b001, 8'h00, 1'b1, w);
      repeat (50) @(negedge clk);

      bus_read(3'b011, 8'h05, "status_final");
      chk("dut2_status_read", dout2, 8'h05);
      chk("frames_outstanding", exp_byte_q.size(), 0);
      chk("p2_frames_outstanding", exp2_q.size(), 0);
      chk("reads_outstanding", rd_exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
